// File: rtl/prism_cfg_sequencer.sv
// prism_cfg_sequencer: streams WIDTH-bit config entries from a small FIFO into
// the PRISM latch loader. For each entry it writes the MSB latch (0x14) with
// setup/hold, shift-loads the low word (0x10), then waits for the chain to
// settle. DEPTH entries make one frame.
// Optional feature macro: PRISM_CFG_CPU_BYPASS_EN (direct CPU writes in IDLE).
module prism_cfg_sequencer #(
  parameter int DEPTH      = 8,
  parameter int WIDTH      = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           ent_valid,
  output logic                           ent_ready,
  input  logic [WIDTH-1:0]               ent_data,
  input  logic                           cpu_wr,
  input  logic [5:0]                     cpu_addr,
  input  logic [31:0]                    cpu_data,
  output logic                           cpu_err,
  output logic [5:0]                     ld_addr,
  output logic [31:0]                    ld_data,
  output logic                           ld_debug_wr,
  output logic                           ld_latch_wr,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(DEPTH+1)-1:0]     loaded
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(3 * DEPTH + 2);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(3 * DEPTH);
  localparam logic [5:0]    ADDR_MSB    = 6'h14;
  localparam logic [5:0]    ADDR_SHIFT  = 6'h10;

  typedef enum logic [2:0] {
    IDLE, FETCH, MSB_SETUP, MSB_WR, MSB_HOLD, LOAD, SETTLE
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PW:0]         count_q, count_d;
  logic [WIDTH-1:0]    entry_q, entry_d, head;
  logic [CW-1:0]       settle_q, settle_d;
  logic                pend_q, pend_d;
  logic [LW-1:0]       loaded_d, loaded_inc;
  logic [5:0]          ld_addr_d;
  logic [31:0]         ld_data_d;
  logic                dbg_d, lat_d, done_d, cpu_err_d;
  logic                push, pop, start_ok, abort_any;

  assign head       = mem[rd_ptr_q];
  assign push       = ent_valid && ent_ready;
  assign pop        = (state_q == LOAD);
  assign start_ok   = (state_q == IDLE) && start && !abort;
  assign abort_any  = abort || pend_q;
  assign loaded_inc = loaded + 1'b1;

`ifndef PRISM_CFG_CPU_BYPASS_EN
  logic cpu_unused;
  assign cpu_unused = ^{cpu_wr, cpu_addr, cpu_data};
`endif

  // FIFO occupancy: abort flushes, simultaneous push/pop leaves count as is
  always_comb begin
    count_d = count_q;
    if (abort) begin
      count_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Next state and next registered output values
  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    settle_d  = settle_q;
    loaded_d  = loaded;
    pend_d    = pend_q || (abort && state_q != IDLE);
    ld_addr_d = ld_addr;
    ld_data_d = ld_data;
    dbg_d     = 1'b0;
    lat_d     = 1'b0;
    done_d    = 1'b0;
    cpu_err_d = 1'b0;
`ifdef PRISM_CFG_CPU_BYPASS_EN
    if (cpu_wr && state_q != IDLE) cpu_err_d = 1'b1;
`endif
    unique case (state_q)
      IDLE: begin
        ld_addr_d = '0;
        ld_data_d = '0;
        pend_d    = 1'b0;
        if (start_ok) begin
          loaded_d = '0;
          state_d  = FETCH;
        end
`ifdef PRISM_CFG_CPU_BYPASS_EN
        if (cpu_wr) begin
          if (start_ok) begin
            cpu_err_d = 1'b1;
          end else begin
            ld_addr_d = cpu_addr;
            ld_data_d = cpu_data;
            dbg_d     = 1'b1;
            lat_d     = 1'b1;
          end
        end
`endif
      end
      FETCH: begin
        if (abort_any) begin
          state_d = IDLE;
        end else if (count_q != '0) begin
          entry_d   = head;
          ld_addr_d = ADDR_MSB;
          ld_data_d = 32'(head[WIDTH-1:32]);
          state_d   = MSB_SETUP;
        end
      end
      MSB_SETUP: begin
        if (abort_any) state_d = IDLE;
        else begin
          lat_d   = 1'b1;
          state_d = MSB_WR;
        end
      end
      MSB_WR: begin
        if (abort_any) state_d = IDLE;
        else           state_d = MSB_HOLD;
      end
      MSB_HOLD: begin
        if (abort_any) state_d = IDLE;
        else begin
          ld_addr_d = ADDR_SHIFT;
          ld_data_d = entry_q[31:0];
          dbg_d     = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        settle_d = SETTLE_LAST;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == '0) begin
          loaded_d = loaded_inc;
          if (loaded_inc == LW'(DEPTH) || abort_any) state_d = IDLE;
          else                                       state_d = FETCH;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Any exit from a busy state ends the frame: pulse done, drive IDLE zeros
    if (state_q != IDLE && state_d == IDLE) begin
      done_d    = 1'b1;
      pend_d    = 1'b0;
      ld_addr_d = '0;
      ld_data_d = '0;
    end
  end

  // FIFO storage, written on accepted push
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= ent_data;
  end

  // State, FIFO pointers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      entry_q     <= '0;
      settle_q    <= '0;
      pend_q      <= 1'b0;
      loaded      <= '0;
      ld_addr     <= '0;
      ld_data     <= '0;
      ld_debug_wr <= 1'b0;
      ld_latch_wr <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      cpu_err     <= 1'b0;
      ent_ready   <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      if (abort) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      entry_q     <= entry_d;
      settle_q    <= settle_d;
      pend_q      <= pend_d;
      loaded      <= loaded_d;
      ld_addr     <= ld_addr_d;
      ld_data     <= ld_data_d;
      ld_debug_wr <= dbg_d;
      ld_latch_wr <= lat_d;
      done        <= done_d;
      busy        <= (state_d != IDLE);
      cpu_err     <= cpu_err_d;
      ent_ready   <= (count_d != (PW + 1)'(FIFO_DEPTH));
    end
  end

endmodule
